// File: rtl/uv_spi_slave.sv
// uv_spi_slave: SPI mode-0 target (MSB first) that turns SPI frames into word
// read/write requests on the uv req/rsp bus. All SPI pins are oversampled in clk.
// Frame: CMD(8) ADDR(16) then write DATA(32) or read DUMMY(8)+DATA(32).
// Optional build macro UV_SPI_SLV_BURST_EN: data phase continues while cs stays
// low, with word-address auto-increment and read prefetch.
module uv_spi_slave #(
    parameter int ALEN = 12,
    parameter int DLEN = 32,
    parameter int MLEN = DLEN/8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spi_sck,
    input  logic            spi_cs,
    input  logic            spi_sdi,
    output logic            spi_sdo,
    output logic            spi_oen,
    output logic            slv_req_vld,
    input  logic            slv_req_rdy,
    output logic            slv_req_read,
    output logic [ALEN-1:0] slv_req_addr,
    output logic [MLEN-1:0] slv_req_mask,
    output logic [DLEN-1:0] slv_req_data,
    input  logic            slv_rsp_vld,
    output logic            slv_rsp_rdy,
    input  logic [1:0]      slv_rsp_excp,
    input  logic [DLEN-1:0] slv_rsp_data,
    output logic            slv_err
);

`ifdef UV_SPI_SLV_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, DONE} state_t;

    state_t          state;
    logic [2:0]      sck_q, cs_q;
    logic [1:0]      sdi_q;
    logic [5:0]      cnt, lim;
    logic [DLEN-2:0] rx_sr;
    logic [DLEN-1:0] rx_next, tx_sr, tx_buf, pend_data;
    logic [ALEN-1:0] cur_addr, pend_addr;
    logic            is_rd, tx_valid, pend, pend_read, outst, out_read, discard;
    logic            sck_rise, sck_fall, cs_rise, cs_fall, issue, underrun, kill;

    assign slv_req_mask = '1;
    assign slv_rsp_rdy  = 1'b1;
    assign spi_sdo      = tx_sr[DLEN-1];

    assign sck_rise = !cs_q[1] &&  sck_q[1] && !sck_q[2];
    assign sck_fall = !cs_q[1] && !sck_q[1] &&  sck_q[2];
    assign cs_rise  =  cs_q[1] && !cs_q[2];
    assign cs_fall  = !cs_q[1] &&  cs_q[2];
    assign rx_next  = {rx_sr, sdi_q[1]};
    assign issue    = !slv_req_vld && pend && !outst;
    // first fall of a data word with nothing loaded to send
    assign underrun = sck_fall && state == RDATA && cnt == 6'd0 && !tx_valid;
    // events after which any read still in flight belongs to no one
    assign kill     = (cs_rise && state != IDLE) || underrun;

    // bits per phase, minus one
    always_comb begin
        lim = 6'd31;
        case (state)
            CMD:     lim = 6'd7;
            ADDR:    lim = 6'd15;
            DUMMY:   lim = 6'd7;
            default: lim = 6'd31;
        endcase
    end

    // two-flop synchronizers plus a third stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 3'b000;
            cs_q  <= 3'b111;
            sdi_q <= 2'b00;
        end else begin
            sck_q <= {sck_q[1:0], spi_sck};
            cs_q  <= {cs_q[1:0], spi_cs};
            sdi_q <= {sdi_q[0], spi_sdi};
        end
    end

    // MISO is driven only while the master expects read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) spi_oen <= 1'b1;
        else        spi_oen <= !(state == DUMMY || state == RDATA);
    end

    // frame FSM, bus request/response tracking and shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rx_sr        <= '0;
            tx_sr        <= '1;
            tx_buf       <= '0;
            tx_valid     <= 1'b0;
            is_rd        <= 1'b0;
            cur_addr     <= '0;
            pend         <= 1'b0;
            pend_read    <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            outst        <= 1'b0;
            out_read     <= 1'b0;
            discard      <= 1'b0;
            slv_req_vld  <= 1'b0;
            slv_req_read <= 1'b0;
            slv_req_addr <= '0;
            slv_req_data <= '0;
            slv_err      <= 1'b0;
        end else begin
            slv_err <= (slv_rsp_vld && slv_rsp_excp != 2'b00) || underrun;

            // one request in flight: present it, hold until accepted
            if (slv_req_vld && slv_req_rdy) begin
                slv_req_vld <= 1'b0;
                outst       <= 1'b1;
                out_read    <= slv_req_read;
            end else if (issue) begin
                slv_req_vld  <= 1'b1;
                slv_req_read <= pend_read;
                slv_req_addr <= pend_addr;
                slv_req_data <= pend_data;
                pend         <= 1'b0;
            end

            // a late or orphaned read response is swallowed
            if (slv_rsp_vld) begin
                outst <= 1'b0;
                if (out_read) begin
                    discard <= 1'b0;
                    if (!discard && !kill) begin
                        tx_buf   <= slv_rsp_data;
                        tx_valid <= 1'b1;
                    end
                end
            end

            if (kill) begin
                tx_valid <= 1'b0;
                if (pend && pend_read && !issue)
                    pend <= 1'b0;
                else if ((slv_req_vld && slv_req_read) || (outst && out_read && !slv_rsp_vld) ||
                         (issue && pend_read))
                    discard <= 1'b1;
            end

            if (cs_rise && state != IDLE) begin
                state <= IDLE;
                cnt   <= '0;
                rx_sr <= '0;
                tx_sr <= '1;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    state <= CMD;
                    cnt   <= '0;
                    rx_sr <= '0;
                end
            end else if (sck_rise && state != DONE) begin
                rx_sr <= rx_next[DLEN-2:0];
                cnt   <= cnt + 6'd1;
                if (cnt == lim) begin
                    cnt <= '0;
                    case (state)
                        CMD: begin
                            is_rd <= (rx_next[7:0] == OP_READ);
                            if (rx_next[7:0] == OP_WRITE || rx_next[7:0] == OP_READ) state <= ADDR;
                            else state <= DONE;
                        end
                        ADDR: begin
                            cur_addr <= rx_next[ALEN-1:0];
                            if (is_rd) begin
                                pend      <= 1'b1;
                                pend_read <= 1'b1;
                                pend_addr <= rx_next[ALEN-1:0];
                                state     <= DUMMY;
                            end else begin
                                state <= WDATA;
                            end
                        end
                        DUMMY: state <= RDATA;
                        WDATA: begin
                            pend      <= 1'b1;
                            pend_read <= 1'b0;
                            pend_addr <= cur_addr;
                            pend_data <= rx_next;
                            cur_addr  <= cur_addr + ALEN'(1);
                            state     <= BURST ? WDATA : DONE;
                        end
                        RDATA: begin
                            if (!BURST) begin
                                state <= DONE;
                                tx_sr <= '1;
                            end
                        end
                        default: state <= DONE;
                    endcase
                end
            end else if (sck_fall && state == RDATA) begin
                if (cnt == 6'd0) begin
                    // word boundary: load response (or all ones on underrun)
                    tx_sr    <= tx_valid ? tx_buf : '1;
                    tx_valid <= 1'b0;
                    if (BURST) begin
                        pend      <= 1'b1;
                        pend_read <= 1'b1;
                        pend_addr <= cur_addr + ALEN'(1);
                        cur_addr  <= cur_addr + ALEN'(1);
                    end
                end else begin
                    tx_sr <= {tx_sr[DLEN-2:0], 1'b1};
                end
            end
        end
    end

endmodule
